// File: rtl/cic_decim_n_if.sv
// Sample-stream bundle for the CIC decimator.
//
// Purpose: carries the input sample stream and the decimated output stream
// between a producer/consumer (master) and the decimator (slave).
//
// Signals:
//   x_in      signed input sample, BITS wide
//   x_valid   x_in is valid this cycle; no back-pressure on the input side
//   x_out     signed 16-bit decimated sample
//   out_valid x_out holds an unconsumed sample
//   out_ready consumer accepts x_out
//   sat       one-cycle pulse, aligned with the x_out load, when x_out was clipped
//
// Handshake: a sample is transferred on every rising clock edge where
// out_valid and out_ready are both high. While out_valid is high and
// out_ready is low, x_out and out_valid hold. The only exception is a newer
// sample arriving before the old one was taken: x_out is then overwritten
// and the loss is flagged by the decimator's sticky overrun output.
interface cic_decim_n_if #(
  parameter int BITS = 6
);
  logic signed [BITS-1:0] x_in;
  logic                   x_valid;
  logic signed [15:0]     x_out;
  logic                   out_valid;
  logic                   out_ready;
  logic                   sat;

  modport master (
    output x_in, x_valid, out_ready,
    input  x_out, out_valid, sat
  );

  modport slave (
    input  x_in, x_valid, out_ready,
    output x_out, out_valid, sat
  );
endinterface

// File: rtl/cic_decim_n.sv
// CIC decimator with a runtime decimation ratio and a serial comb section.
//
// Purpose: STAGES integrators run at the input rate (advanced only on
// x_valid). Every R_eff valid inputs, the last integrator is captured and a
// serial FSM runs the STAGES comb stages one per cycle, then scales
// (arithmetic right shift) and saturates the result to 16 bits.
//
// Ports:
//   CLK        clock, all logic on the rising edge
//   RSTb       synchronous active-low reset
//   bus        cic_decim_n_if slave: x_in/x_valid in, x_out/out_valid/sat out,
//              out_ready in
//   decim      runtime decimation ratio R (clamped to at least STAGES+3)
//   shift      output arithmetic right-shift amount (clamped to WIDTH-16)
//   overrun    sticky flag: an unconsumed output sample was overwritten
//   clr_ovr    clears overrun (a coincident new overrun wins)
//   fsm_state  comb/scale FSM state (0 IDLE, 1 COMB, 2 SCALE)
module cic_decim_n #(
  parameter int STAGES     = 3,
  parameter int DIFF_DELAY = 1,
  parameter int BITS       = 6,
  parameter int WIDTH      = 43,
  parameter int SHIFT_BITS = 6
) (
  input  logic                  CLK,
  input  logic                  RSTb,
  cic_decim_n_if.slave          bus,
  input  logic [15:0]           decim,
  input  logic [SHIFT_BITS-1:0] shift,
  output logic                  overrun,
  input  logic                  clr_ovr,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COMB  = 2'd1,
    SCALE = 2'd2
  } state_t;

  localparam int MIN_R  = STAGES + 3;
  localparam int SH_MAX = WIDTH - 16;
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic signed [WIDTH-1:0] POS_LIM = WIDTH'(32767);
  localparam logic signed [WIDTH-1:0] NEG_LIM = -(WIDTH'(32768));

  // ---------------------------------------------------------------------
  // Integrator section and decimation counter
  // ---------------------------------------------------------------------
  logic signed [WIDTH-1:0] integ [STAGES];
  logic signed [WIDTH-1:0] x_ext;
  logic signed [WIDTH-1:0] sample;
  logic [15:0]             count;
  logic [15:0]             r_eff;
  logic [15:0]             r_clamp;
  logic [15:0]             r_cur;
  logic                    run;
  logic                    wrap;
  logic                    strobe;

  assign x_ext   = {{(WIDTH-BITS){bus.x_in[BITS-1]}}, bus.x_in};
  assign r_clamp = (decim < 16'(MIN_R)) ? 16'(MIN_R) : decim;
  // In the first cycle after reset r_eff is still being latched, so the
  // period compare uses the clamped input directly.
  assign r_cur   = run ? r_eff : r_clamp;
  assign wrap    = bus.x_valid && (count == r_cur - 16'd1);

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      for (int k = 0; k < STAGES; k++) integ[k] <= '0;
      count  <= '0;
      r_eff  <= '0;
      run    <= 1'b0;
      sample <= '0;
      strobe <= 1'b0;
    end else begin
      run    <= 1'b1;
      strobe <= wrap;
      // The ratio only changes at a period boundary.
      if (!run || wrap) r_eff <= r_clamp;
      if (bus.x_valid) begin
        integ[0] <= integ[0] + x_ext;
        // Right-hand sides are the pre-update values: a pipelined cascade.
        for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
        count <= wrap ? 16'd0 : count + 16'd1;
      end
      if (wrap) sample <= integ[STAGES-1];
    end
  end

  // ---------------------------------------------------------------------
  // Serial comb FSM
  // ---------------------------------------------------------------------
  state_t state, state_nx;
  logic [SW-1:0] stage;

  always_ff @(posedge CLK) begin
    if (!RSTb) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (strobe) state_nx = COMB;
      COMB:    if (stage == SW'(STAGES-1)) state_nx = SCALE;
      SCALE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign fsm_state = state;

  // ---------------------------------------------------------------------
  // Scale and saturate
  // ---------------------------------------------------------------------
  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] scaled;
  logic [31:0]             sh_eff;
  logic signed [15:0]      sat_val;
  logic                    clip;

  always_comb begin
    sh_eff  = (32'(shift) > 32'(SH_MAX)) ? 32'(SH_MAX) : 32'(shift);
    scaled  = acc >>> sh_eff;
    clip    = 1'b0;
    sat_val = scaled[15:0];
    if (scaled > POS_LIM) begin
      clip    = 1'b1;
      sat_val = 16'sh7fff;
    end else if (scaled < NEG_LIM) begin
      clip    = 1'b1;
      sat_val = 16'sh8000;
    end
  end

  // ---------------------------------------------------------------------
  // Comb datapath and output register
  // ---------------------------------------------------------------------
  logic signed [WIDTH-1:0] dline [STAGES][DIFF_DELAY];
  logic signed [15:0]      x_out_r;
  logic                    out_valid_r;
  logic                    sat_r;

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      acc   <= '0;
      stage <= '0;
      for (int k = 0; k < STAGES; k++)
        for (int j = 0; j < DIFF_DELAY; j++) dline[k][j] <= '0;
      x_out_r     <= '0;
      out_valid_r <= 1'b0;
      sat_r       <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sat_r <= 1'b0;
      if (out_valid_r && bus.out_ready) out_valid_r <= 1'b0;
      if (clr_ovr) overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe) begin
            acc   <= sample;
            stage <= '0;
          end
        end
        COMB: begin
          // acc holds y_(k-1) on entry and y_k on exit.
          for (int k = 0; k < STAGES; k++) begin
            if (SW'(k) == stage) begin
              acc         <= acc - dline[k][DIFF_DELAY-1];
              dline[k][0] <= acc;
              for (int j = 1; j < DIFF_DELAY; j++) dline[k][j] <= dline[k][j-1];
            end
          end
          stage <= stage + SW'(1);
        end
        SCALE: begin
          // Later assignments override the accept/clear updates above, so a
          // simultaneous accept reloads and a simultaneous clear loses to a
          // fresh overrun.
          x_out_r     <= sat_val;
          out_valid_r <= 1'b1;
          sat_r       <= clip;
          if (out_valid_r && !bus.out_ready) overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.x_out     = x_out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sat       = sat_r;

endmodule
